// File: rtl/iob_native2simplebus_pkg.sv
// Shared types and field positions for the IOb-native to simple-bus bridge.
package iob_native2simplebus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int WSTRB_LSB = 0;
  localparam int READY_POS = 0;
  localparam int RDATA_LSB = 1;

  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int valid_pos(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int wdata_lsb(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/iob_strb_decode.sv
// Maps a 4-lane byte strobe to simple-bus size/offset, or flags it
// for splitting into single-byte writes.
module iob_strb_decode
  import iob_native2simplebus_pkg::*;
(
  input  logic [3:0] i_strb,
  output logic       o_read,
  output logic [1:0] o_size,
  output logic [1:0] o_offset,
  output logic       o_split,
  output logic [1:0] o_first,
  output logic [3:0] o_rest
);

  always_comb begin
    o_first = 2'd0;
    if (i_strb[0])      o_first = 2'd0;
    else if (i_strb[1]) o_first = 2'd1;
    else if (i_strb[2]) o_first = 2'd2;
    else if (i_strb[3]) o_first = 2'd3;
  end

  assign o_rest = i_strb & ~(4'b0001 << o_first);

  always_comb begin
    o_read   = 1'b0;
    o_split  = 1'b0;
    o_size   = SZ_BYTE;
    o_offset = o_first;
    unique case (i_strb)
      4'b0000: begin
        o_read   = 1'b1;
        o_size   = SZ_WORD;
        o_offset = 2'd0;
      end
      4'b1111: begin
        o_size   = SZ_WORD;
        o_offset = 2'd0;
      end
      4'b0011: begin
        o_size   = SZ_HALF;
        o_offset = 2'd0;
      end
      4'b1100: begin
        o_size   = SZ_HALF;
        o_offset = 2'd2;
      end
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: o_size = SZ_BYTE;
      default:          o_split = 1'b1;
    endcase
  end

endmodule

// File: rtl/iob_native2simplebus.sv
// IOb-native responder replayed as a simple cmd/rsp bus initiator,
// one transaction in flight, with read timeout and sticky error.
module iob_native2simplebus
  import iob_native2simplebus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [req_w(ADDR_W,DATA_W)-1:0] s_req,
  output logic [resp_w(DATA_W)-1:0]       s_resp,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic                            cmd_wr,
  output logic [ADDR_W-1:0]               cmd_address,
  output logic [DATA_W-1:0]               cmd_data,
  output logic [1:0]                      cmd_size,
  input  logic                            rsp_valid,
  input  logic                            rsp_error,
  input  logic [DATA_W-1:0]               rsp_data,
  input  logic                            err_clr,
  output logic                            err
);

  localparam int VP = valid_pos(ADDR_W, DATA_W);
  localparam int AL = addr_lsb(DATA_W);
  localparam int WL = wdata_lsb(DATA_W);
  localparam int SW = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] T_LAST =
    TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t r_state, w_nstate;

  logic                 r_cmd_valid;
  logic                 r_cmd_wr;
  logic [ADDR_W-1:0]    r_cmd_addr;
  logic [DATA_W-1:0]    r_cmd_data;
  logic [1:0]           r_cmd_size;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_ready;
  logic                 r_err;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [3:0]           r_rem;

  logic              w_valid;
  logic [ADDR_W-3:0] w_addr_hi;
  logic [DATA_W-1:0] w_wdata;
  logic [SW-1:0]     w_wstrb;

  assign w_valid   = s_req[VP];
  assign w_addr_hi = s_req[AL+2 +: ADDR_W-2];
  assign w_wdata   = s_req[WL +: DATA_W];
  assign w_wstrb   = s_req[WSTRB_LSB +: SW];

  logic       w_dec_read, w_dec_split;
  logic [1:0] w_dec_size, w_dec_off, w_dec_first;
  logic [3:0] w_dec_rest, w_dec_in;

  // IDLE decodes the new request; CMD walks the remaining split lanes
  assign w_dec_in = (r_state == ST_IDLE) ? w_wstrb : r_rem;

  iob_strb_decode u_dec (
    .i_strb   (w_dec_in),
    .o_read   (w_dec_read),
    .o_size   (w_dec_size),
    .o_offset (w_dec_off),
    .o_split  (w_dec_split),
    .o_first  (w_dec_first),
    .o_rest   (w_dec_rest)
  );

  logic w_accept, w_rsp, w_timeout, w_err_set;

  assign w_accept  = r_cmd_valid & cmd_ready;
  assign w_rsp     = (r_state == ST_WAIT) & rsp_valid;
  assign w_timeout = (r_state == ST_WAIT) & ~rsp_valid &
                     (r_cnt == T_LAST);
  assign w_err_set = (w_rsp & rsp_error) | w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE: if (w_valid) w_nstate = ST_CMD;
      ST_CMD: begin
        if (w_accept) begin
          if (!r_cmd_wr)         w_nstate = ST_WAIT;
          else if (r_rem == '0)  w_nstate = ST_RESP;
        end
      end
      ST_WAIT: if (w_rsp || w_timeout) w_nstate = ST_RESP;
      ST_RESP: w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_cmd_size  <= 2'd0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_cnt       <= '0;
      r_rem       <= 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_cmd_valid <= 1'b1;
            r_cmd_wr    <= ~w_dec_read;
            r_cmd_addr  <= {w_addr_hi, w_dec_off};
            r_cmd_data  <= w_wdata;
            r_cmd_size  <= w_dec_size;
            r_rem       <= w_dec_split ? w_dec_rest : 4'd0;
            r_rdata     <= '0;
          end
        end
        ST_CMD: begin
          if (w_accept) begin
            if (!r_cmd_wr) begin
              r_cmd_valid <= 1'b0;
              r_cnt       <= '0;
            end else if (r_rem != 4'd0) begin
              r_cmd_addr <= {r_cmd_addr[ADDR_W-1:2], w_dec_first};
              r_cmd_size <= SZ_BYTE;
              r_rem      <= w_dec_rest;
            end else begin
              r_cmd_valid <= 1'b0;
              r_ready     <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (rsp_valid) begin
            r_rdata <= rsp_data;
            r_ready <= 1'b1;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_ready <= 1'b1;
          end
        end
        ST_RESP: r_ready <= 1'b0;
        default: r_ready <= 1'b0;
      endcase
    end
  end

  // a new error outranks a clear arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_set | (r_err & ~err_clr);
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_wr      = r_cmd_wr;
  assign cmd_address = r_cmd_addr;
  assign cmd_data    = r_cmd_data;
  assign cmd_size    = r_cmd_size;
  assign s_resp      = {r_rdata, r_ready};
  assign err         = r_err;

endmodule

// File: doc/iob_native2simplebus.md
Name: iob_native2simplebus

Overview:
- Bridge that answers IOb-native requests as a responder and replays them as an initiator on a VexRiscv-style simple cmd/rsp bus.
- Lets SoC masters reach slaves built for the VexRiscv dBus, such as simple-bus memories and peripheral wrappers.
- Converts byte strobes to size/offset, splits non-contiguous strobes into byte writes, enforces a response timeout and keeps a sticky error flag.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; only 32 is supported, because the size encoding assumes 4 byte lanes.
- TIMEOUT_W, 8, width of the wait counter; timeout fires after 2^TIMEOUT_W-1 cycles in WAIT. Minimum value 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_req  in  1+ADDR_W+DATA_W+DATA_W/8  IOb-native request {valid, addr, wdata, wstrb}; wstrb==0 means read.
- s_resp  out  DATA_W+1  IOb-native response {rdata, ready}; ready is bit 0.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  command accepted.
- cmd_wr  out  1  1=write.
- cmd_address  out  ADDR_W  byte address, aligned to the size.
- cmd_data  out  DATA_W  write data, lane-positioned as in wdata.
- cmd_size  out  2  0=byte, 1=half, 2=word.
- rsp_valid  in  1  read response valid.
- rsp_error  in  1  read response error.
- rsp_data  in  DATA_W  read data.
- err_clr  in  1  clears the sticky error.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, any state): FSM returns to IDLE. cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_size, s_resp (rdata and ready), err and the timeout counter all go to 0. An in-flight transaction is dropped; no response is issued.
- All outputs are registered.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE:
  - Samples s_req.valid.
  - When valid=1, captures addr, wdata and wstrb, computes the decode, drives the cmd_* registers and cmd_valid=1, and enters CMD.
- Strobe decode (wstrb -> size, addr[1:0]):
  - 0000 -> read: size 2, addr[1:0]=00.
  - 1111 -> size 2, 00.
  - 0011 -> size 1, 00.
  - 1100 -> size 1, 10.
  - Single bit k -> size 0, offset k.
  - Any other pattern -> split.
  - addr[ADDR_W-1:2] always passes through unchanged.
- Split:
  - Issues one byte write per set strobe bit, lowest bit first.
  - A remaining-strobe register clears each bit as its command is accepted.
- CMD:
  - cmd_valid stays high and the payload stays stable until cmd_ready=1.
  - On acceptance:
    - read -> cmd_valid=0, WAIT, timeout counter cleared;
    - write with bits remaining -> load the next byte command (cmd_valid stays 1), stay in CMD;
    - final write -> cmd_valid=0, RESP.
- Writes get no simple-bus response.
- WAIT:
  - Counter increments every cycle.
  - On rsp_valid=1: rdata<=rsp_data, and err<=1 if rsp_error=1; go to RESP.
  - If the counter reaches 2^TIMEOUT_W-1 without rsp_valid: rdata<=0, err<=1, go to RESP.
  - rsp_valid in any other state is ignored.
- RESP:
  - s_resp.ready=1 for exactly one cycle; rdata holds its value; next state IDLE.
  - s_req is not sampled in RESP, because the requester still shows the old request.
  - rdata is 0 for writes.
- Latency, zero-wait slave:
  - write: ready 2 cycles after valid is first seen;
  - read: ready 3 cycles after valid when rsp_valid arrives the cycle after cmd acceptance;
  - split write with n set bits: ready n+1 cycles after valid.
- Back-to-back requests: a new valid is sampled in the IDLE cycle right after RESP, giving 1 idle cycle minimum between responses.
- err:
  - set on rsp_error or timeout; cleared by err_clr;
  - if set and clear happen in the same cycle, set wins.
- A timeout does not cancel a late rsp_valid on the slave side; a late rsp_valid arriving in IDLE, CMD or RESP is discarded.

Decomposition:
- Shared header/package:
  - FSM state encodings (2 bits);
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - s_req/s_resp field positions, reusing the existing intercon REQ_W/RESP_W/valid/address/wdata/wstrb/rdata/ready macros.
- One natural sub-module, iob_strb_decode (combinational):
  - inputs: wstrb (or remaining strobe);
  - outputs: read, size, offset[1:0], split, first-set-bit index, mask of remaining bits after the first.

Test Plan:
- Read, slave cmd_ready=1, rsp_valid one cycle after acceptance with rsp_data=0x12345678, addr 0x1007 -> cmd_address=0x1004, size=2, wr=0; ready pulses 1 cycle with rdata=0x12345678; err=0.
- Write wstrb=1100, addr 0x2000, wdata 0xAABB0000 -> one command, size=1, cmd_address=0x2002, cmd_data=0xAABB0000; ready 2 cycles after valid.
- Write wstrb=0101, cmd_ready stalled low 3 cycles on each command -> two byte writes at 0x..0 then 0x..2, payload stable during stalls; one ready at the end.
- Read with no rsp_valid, TIMEOUT_W=3 -> ready after 7 WAIT cycles with rdata=0 and err=1. Then pulse err_clr -> err=0. Then assert err_clr in the same cycle as an rsp_error response -> err stays 1.
- Reset asserted mid-CMD of a split write -> all outputs 0 immediately (asynchronously); no ready pulse; the next request is served normally.
- Back-to-back requests with valid held high: write then read -> ready pulses separated by at least 1 cycle; the second request is not sampled in the RESP cycle of the first.
